bus_sched_ctrl: RTL and testbench
=================================

Name: bus_sched_ctrl

Overview:
- Round-robin bus scheduler for the four-master shared bus. It is a drop-in controller for the master-mux grant vector.
- Holds a grant for a whole transaction, from address strobe until slave ready.
- Enforces a per-tenure burst limit so no master starves the others.
- Watchdogs the selected slave's ready line: a slave that never answers cannot hang the bus.

Parameters:
- TMO_CYCLES, 255: cycles in WAIT without s_rdy before timeout; legal range 2..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.
- BURST_MAX, 4: completed transactions per tenure before the grant is yielded to another requester; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  4  bus request, one bit per master 0..3.
- m_as  in  4  address strobe per master, active-high; only the bit for the current owner is used.
- s_rdy  in  1  ready from the selected slave, i.e. the slave-mux m_rdy.
- grnt  out  4  registered grant; one-hot or all-zero.
- owner  out  2  index of the current or last granted master.
- busy  out  1  high when state ≠ IDLE.
- tmo_err  out  1  one-cycle pulse when a transaction times out.
- tmo_master  out  2  owner at the last timeout; holds its value until the next timeout.

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - Outputs: grnt=0, owner=0, busy=0, tmo_err=0, tmo_master=0.
  - Internal: state=IDLE, last=3 (master 0 has first priority), burst_cnt=0, timer=0.
  - A reset mid-transaction drops the grant in that same edge; no tmo_err is issued.
- States: IDLE, GRANT, WAIT. All outputs are registered.
- IDLE:
  - If req≠0, pick the first set bit scanning last+1, last+2, ... modulo 4.
  - Next edge: grnt=onehot(pick), owner=pick, burst_cnt=0, state=GRANT.
  - Latency from req to grnt is 1 cycle.
- GRANT (grnt held):
  - m_as[owner]=1 and s_rdy=1 in the same cycle: zero-wait transaction. burst_cnt+1, saturating at BURST_MAX; stay in GRANT.
  - m_as[owner]=1 and s_rdy=0: state=WAIT, timer=0.
  - m_as[owner]=0 and req[owner]=0: release.
  - m_as[owner]=0, burst_cnt==BURST_MAX, and any other req bit set: release (fairness yield).
  - Otherwise: hold.
- WAIT (grnt frozen; m_as and req changes ignored):
  - s_rdy=1: burst_cnt+1 (saturating), state=GRANT.
  - s_rdy=0 and timer==TMO_CYCLES-1: tmo_err=1 for one cycle, tmo_master=owner, then release.
  - Otherwise: timer+1.
- Release:
  - Next edge: grnt=0, last=owner, state=IDLE; owner keeps its value.
  - This leaves a mandatory one-cycle all-zero grnt gap between tenures, so master-mux outputs never glitch between owners.
- Re-arbitration in IDLE uses the updated last pointer, so the released master has lowest priority.
- Single requester: the grant never yields for burst reasons. burst_cnt saturates and no dead cycles are inserted.
- s_rdy in IDLE is ignored. m_as from non-owners is always ignored.
- A timeout release counts as a release for round-robin purposes.

Optional Feature:
- Macro: BUS_SCHED_TMO_EN.
- Defined: watchdog as described above.
- Undefined:
  - The timer is not synthesised; WAIT exits only on s_rdy.
  - tmo_err and tmo_master are tied to 0.
  - The TMO_CYCLES and CNT_W parameters remain but are unused.

Test Plan:
- Reset then req=4'b0001 → grnt=0001 one cycle later, busy=1. Drop req with m_as=0 → grnt=0000 next edge, busy=0.
- req=4'b1111 held, each master doing a single 1-wait-state transaction then dropping req → grant order 0,1,2,3,0, with exactly one grnt=0000 cycle between tenures.
- BURST_MAX=4, req=4'b0011 held, master 0 doing back-to-back zero-wait transactions → master 0 holds for 4 completions, then grnt=0000 for one cycle, then grnt=0010.
- TMO_CYCLES=8, master 2 granted, m_as[2]=1, s_rdy held 0 → 8 cycles in WAIT, then tmo_err=1 for exactly one cycle, tmo_master=2, grnt=0000 next edge. Same case with the macro undefined → grant held indefinitely, tmo_err stays 0.
- Master 1 in WAIT; assert rst=1 for one cycle → at that edge grnt=0000, state=IDLE, tmo_err=0. With req=4'b0010 still high after reset → grnt=0010 after 1 cycle.
- Master 3 in WAIT with req=4'b0001 also asserted, s_rdy=1 arriving after 3 cycles → grnt stays 1000 throughout WAIT, returns to GRANT. Master 3 then drops req → grnt=0000, then grnt=0001.

Source files
------------

// File: rtl/bus_sched_ctrl.sv
// bus_sched_ctrl: round-robin grant controller for the four-master shared bus.
// A grant is held from address strobe until slave ready. A per-tenure burst
// limit makes a busy master yield, and an optional watchdog frees the bus when
// the selected slave never answers.
// Build option: define BUS_SCHED_TMO_EN to include the slave-ready watchdog.
// Without it, WAIT exits only on s_rdy and tmo_err/tmo_master read as zero.
//
// state | meaning
// IDLE  | no grant; arbitrate among req, starting after the last owner
// GRANT | grant held; owner may issue a transaction or release the bus
// WAIT  | transaction issued; grant frozen until s_rdy (or watchdog expiry)
module bus_sched_ctrl #(
   parameter int TMO_CYCLES = 255,
   parameter int CNT_W      = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] m_as,
   input  logic       s_rdy,
   output logic [3:0] grnt,
   output logic [1:0] owner,
   output logic       busy,
   output logic       tmo_err,
   output logic [1:0] tmo_master
);

   localparam int              BC_W      = $clog2(BURST_MAX + 1);
   localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic [1:0]      last;
   logic [BC_W-1:0] burst_cnt;

   logic [1:0] pick;
   logic [1:0] cand;
   logic       req_any;
   logic       others_req;
   logic       burst_full;
   logic       do_grant;
   logic       do_wait;
   logic       do_done;
   logic       do_tmo;
   logic       do_rel;

   // Reject parameter values outside their legal ranges at elaboration.
   generate
      if (BURST_MAX < 1) begin : g_bad_burst
         $error("bus_sched_ctrl: BURST_MAX must be at least 1");
      end
      if ((TMO_CYCLES < 2) || ($clog2(TMO_CYCLES + 1) > CNT_W)) begin : g_bad_tmo
         $error("bus_sched_ctrl: TMO_CYCLES must be 2..2**CNT_W-1");
      end
   endgenerate

   // Round-robin pick: first requester scanning last+1, last+2, ... mod 4.
   always_comb begin
      pick    = last;
      cand    = last;
      req_any = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!req_any && req[cand]) begin
            pick    = cand;
            req_any = 1'b1;
         end
      end
   end

`ifdef BUS_SCHED_TMO_EN
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYCLES - 1);

   logic [CNT_W-1:0] timer;

   // Watchdog down-counter: loaded on WAIT entry, expiry when it reaches zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer      <= '0;
         tmo_err    <= 1'b0;
         tmo_master <= 2'd0;
      end else begin
         tmo_err <= do_tmo;
         if (do_tmo) begin
            tmo_master <= owner;
         end
         if (do_wait) begin
            timer <= TMO_LOAD;
         end else if ((state == WAIT) && (timer != '0)) begin
            timer <= timer - CNT_W'(1);
         end
      end
   end
`else
   assign tmo_err    = 1'b0;
   assign tmo_master = 2'd0;
`endif

   // Per-cycle decisions for the current state; the FSM below registers them.
   always_comb begin
      others_req = |(req & ~grnt);
      burst_full = (burst_cnt == BURST_LIM);
      do_grant   = (state == IDLE) && req_any;
      do_wait    = (state == GRANT) && m_as[owner] && !s_rdy;
      do_done    = ((state == GRANT) && m_as[owner] && s_rdy) ||
                   ((state == WAIT) && s_rdy);
`ifdef BUS_SCHED_TMO_EN
      do_tmo     = (state == WAIT) && !s_rdy && (timer == '0);
`else
      do_tmo     = 1'b0;
`endif
      // A timeout release counts as an ordinary release for round-robin.
      do_rel     = ((state == GRANT) && !m_as[owner] &&
                    (!req[owner] || (burst_full && others_req))) || do_tmo;
   end

   // Scheduler FSM with registered grant, owner and busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grnt      <= 4'b0000;
         owner     <= 2'd0;
         busy      <= 1'b0;
         last      <= 2'd3;
         burst_cnt <= '0;
      end else if (do_grant) begin
         grnt      <= 4'b0001 << pick;
         owner     <= pick;
         burst_cnt <= '0;
         busy      <= 1'b1;
         state     <= GRANT;
      end else if (do_rel) begin
         // Dropping to all-zero for one cycle keeps the master mux glitch-free.
         grnt  <= 4'b0000;
         last  <= owner;
         busy  <= 1'b0;
         state <= IDLE;
      end else begin
         if (do_wait) begin
            state <= WAIT;
         end
         if (do_done) begin
            state <= GRANT;
            // Saturate so a lone requester never wraps into a false yield.
            if (!burst_full) begin
               burst_cnt <= burst_cnt + BC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bus_sched_ctrl.sv
// Directed bench for bus_sched_ctrl. The stimulus pushes the expected grant
// changes and timeout pulses into queues; a monitor pops and compares them as
// the DUT presents each change.
module tb_bus_sched_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] m_as;
   logic       s_rdy;
   logic [3:0] grnt;
   logic [1:0] owner;
   logic       busy;
   logic       tmo_err;
   logic [1:0] tmo_master;

   always #5 clk = ~clk;

   bus_sched_ctrl #(
      .TMO_CYCLES (8),
      .CNT_W      (8),
      .BURST_MAX  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .m_as       (m_as),
      .s_rdy      (s_rdy),
      .grnt       (grnt),
      .owner      (owner),
      .busy       (busy),
      .tmo_err    (tmo_err),
      .tmo_master (tmo_master)
   );

   typedef struct {
      logic [3:0] g;
      logic [1:0] o;
      logic       b;
      int         hold;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] tmo_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   bit         mon_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, expv, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // hold: cycles the previous grnt value must have lasted, -1 = don't care
   task automatic push(input logic [3:0] g, input logic [1:0] o, input logic b, input int hold);
      exp_t e;
      e.g    = g;
      e.o    = o;
      e.b    = b;
      e.hold = hold;
      exp_q.push_back(e);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin : monitor
      logic [3:0] prev_g;
      int         hold_cnt;
      exp_t       e;
      logic [1:0] tm;
      wait (mon_en);
      prev_g   = grnt;
      hold_cnt = 0;
      forever begin
         @(negedge clk);
         if (grnt !== prev_g) begin
            if (exp_q.size() == 0) begin
               chk("grnt_unexpected", 32'(grnt), 32'(prev_g));
            end else begin
               e = exp_q.pop_front();
               chk("grnt", 32'(grnt), 32'(e.g));
               chk("owner", 32'(owner), 32'(e.o));
               chk("busy", 32'(busy), 32'(e.b));
               if (e.hold >= 0) chk("hold_cycles", 32'(hold_cnt), 32'(e.hold));
            end
            prev_g   = grnt;
            hold_cnt = 1;
         end else begin
            hold_cnt++;
         end
         if (tmo_err) begin
            if (tmo_q.size() == 0) begin
               chk("tmo_err_unexpected", 32'(tmo_err), 32'(0));
            end else begin
               tm = tmo_q.pop_front();
               chk("tmo_master", 32'(tmo_master), 32'(tm));
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: bench did not finish, actual timeout required completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      rst   = 1'b1;
      req   = 4'b0000;
      m_as  = 4'b0000;
      s_rdy = 1'b0;
      repeat (3) tick();
      chk("rst_grnt", 32'(grnt), 32'(0));
      chk("rst_owner", 32'(owner), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_tmo_err", 32'(tmo_err), 32'(0));
      chk("rst_tmo_master", 32'(tmo_master), 32'(0));
      rst    = 1'b0;
      mon_en = 1'b1;
      tick();

      // single request, then drop; s_rdy in IDLE must be ignored
      s_rdy = 1'b1;
      tick();
      s_rdy = 1'b0;
      req = 4'b0001; push(4'b0001, 2'd0, 1'b1, -1); tick();
      req = 4'b0000; push(4'b0000, 2'd0, 1'b0, 1);  tick();
      repeat (2) tick();
      pulse_reset();

      // all four requesting, one 1-wait-state transaction each: order 0,1,2,3,0
      req = 4'b1111; push(4'b0001, 2'd0, 1'b1, -1); tick();
      for (int k = 0; k < 5; k++) begin
         int m;
         int n;
         m = k % 4;
         n = (m + 1) % 4;
         m_as = 4'(1 << m); s_rdy = 1'b0; tick();
         m_as = 4'b0000;    s_rdy = 1'b1; tick();
         s_rdy = 1'b0;
         req = 4'b1111 & ~4'(1 << m);
         push(4'b0000, 2'(m), 1'b0, 3);
         tick();
         if (k < 4) begin
            req = 4'b1111;
            push(4'(1 << n), 2'(n), 1'b1, 1);
            tick();
         end
      end
      req = 4'b0000;
      repeat (2) tick();
      pulse_reset();

      // burst limit: master 0 yields to master 1 after 4 completions
      req = 4'b0011; push(4'b0001, 2'd0, 1'b1, -1); tick();
      m_as = 4'b0001; s_rdy = 1'b1; repeat (4) tick();
      m_as = 4'b0000; s_rdy = 1'b0;
      push(4'b0000, 2'd0, 1'b0, 5); tick();
      push(4'b0010, 2'd1, 1'b1, 1); tick();
      req = 4'b0001; push(4'b0000, 2'd1, 1'b0, 1); tick();
      push(4'b0001, 2'd0, 1'b1, 1); tick();
      // lone requester: counter saturates, no yield until a rival appears
      m_as = 4'b0001; s_rdy = 1'b1; repeat (6) tick();
      m_as = 4'b0000; s_rdy = 1'b0; tick();
      req = 4'b0011; push(4'b0000, 2'd0, 1'b0, 8); tick();
      req = 4'b0010; push(4'b0010, 2'd1, 1'b1, 1); tick();
      req = 4'b0000; push(4'b0000, 2'd1, 1'b0, 1); tick();
      tick();

      // slave never answers master 2; req/m_as changes in WAIT are ignored
      req = 4'b0100; push(4'b0100, 2'd2, 1'b1, -1); tick();
      m_as = 4'b0100; tick();
      m_as = 4'b0000; req = 4'b0000;
`ifdef BUS_SCHED_TMO_EN
      push(4'b0000, 2'd2, 1'b0, 9);
      tmo_q.push_back(2'd2);
      repeat (8) tick();
      repeat (2) tick();
      chk("tmo_master_holds", 32'(tmo_master), 32'(2));
      chk("tmo_err_cleared", 32'(tmo_err), 32'(0));
`else
      repeat (20) tick();
      chk("wait_grnt_frozen", 32'(grnt), 32'(4'b0100));
      chk("wait_busy", 32'(busy), 32'(1));
      chk("tmo_err_off", 32'(tmo_err), 32'(0));
      chk("tmo_master_off", 32'(tmo_master), 32'(0));
      s_rdy = 1'b1; tick();
      s_rdy = 1'b0; push(4'b0000, 2'd2, 1'b0, -1); tick();
      tick();
`endif

      // reset while master 1 waits: grant drops at that edge, no tmo_err
      req = 4'b0010; push(4'b0010, 2'd1, 1'b1, -1); tick();
      m_as = 4'b0010; tick();
      m_as = 4'b0000; tick();
      rst = 1'b1; push(4'b0000, 2'd0, 1'b0, 3); tick();
      chk("rst_mid_tmo_err", 32'(tmo_err), 32'(0));
      chk("rst_mid_busy", 32'(busy), 32'(0));
      rst = 1'b0; push(4'b0010, 2'd1, 1'b1, 1); tick();
      req = 4'b0000; push(4'b0000, 2'd1, 1'b0, 1); tick();
      tick();

      // master 3 waits 3 cycles with master 0 requesting; non-owner m_as ignored
      req = 4'b1001; push(4'b1000, 2'd3, 1'b1, -1); tick();
      m_as = 4'b1000; tick();
      m_as = 4'b0001; repeat (2) tick();
      s_rdy = 1'b1; tick();
      s_rdy = 1'b0; req = 4'b0001; m_as = 4'b0001;
      push(4'b0000, 2'd3, 1'b0, 5); tick();
      m_as = 4'b0000; push(4'b0001, 2'd0, 1'b1, 1); tick();
      req = 4'b0000; push(4'b0000, 2'd0, 1'b0, 1); tick();
      repeat (2) tick();

      chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
      chk("tmo_q_drained", 32'(tmo_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
